// File: rtl/instr_loader.sv
// Byte-serial program loader: takes a length-prefixed, big-endian byte stream and
// writes 32-bit words into instruction memory while holding the CPU in reset.
module instr_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] word_cnt_o
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t      state, state_n;
  logic [15:0] len_q, len_n, len_full;
  logic [1:0]  byte_idx_q, byte_idx_n;
  logic [23:0] shift_q, shift_n;
  logic [31:0] wr_addr_n, wr_data_n;
  logic [15:0] word_cnt_n;
  logic        accept;
  logic        settled;
  logic        in_ready_n, wr_en_n, cpu_hold_n, done_n, err_n;

  assign accept = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      len_q      <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      in_ready_o <= 1'b0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= ADDR_BASE;
      wr_data_o  <= '0;
      cpu_hold_o <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      word_cnt_o <= '0;
    end else begin
      state      <= state_n;
      len_q      <= len_n;
      byte_idx_q <= byte_idx_n;
      shift_q    <= shift_n;
      in_ready_o <= in_ready_n;
      wr_en_o    <= wr_en_n;
      wr_addr_o  <= wr_addr_n;
      wr_data_o  <= wr_data_n;
      cpu_hold_o <= cpu_hold_n;
      done_o     <= done_n;
      err_o      <= err_n;
      word_cnt_o <= word_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    len_n      = len_q;
    byte_idx_n = byte_idx_q;
    shift_n    = shift_q;
    wr_addr_n  = wr_addr_o;
    wr_data_n  = wr_data_o;
    word_cnt_n = word_cnt_o;
    len_full   = {len_q[15:8], in_data_i};

    case (state)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_n    = LEN_HI;
          wr_addr_n  = ADDR_BASE;
          word_cnt_n = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_n[15:8] = in_data_i;
          state_n     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_n      = len_full;
          byte_idx_n = '0;
          if (len_full == 16'd0)
            state_n = DONE;
          else if ({1'b0, len_full} > MAX_LEN)
            state_n = ERR;
          else
            state_n = DATA;
        end
      end
      DATA: begin
        // wr_data_o only changes when a full word is ready, so it never glitches.
        if (accept) begin
          byte_idx_n = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wr_data_n = {shift_q, in_data_i};
            state_n   = WRITE;
          end else begin
            shift_n = {shift_q[15:0], in_data_i};
          end
        end
      end
      WRITE: begin
        wr_addr_n  = wr_addr_o + 32'd4;
        word_cnt_n = word_cnt_o + 16'd1;
        state_n    = (word_cnt_n == len_q) ? DONE : DATA;
      end
      default: state_n = IDLE;
    endcase
  end

  // Release is reported one cycle after DONE is entered, and withdrawn on the start edge.
  always_comb begin
    settled    = (state == DONE) && (state_n == DONE);
    in_ready_n = (state_n == LEN_HI) || (state_n == LEN_LO) || (state_n == DATA);
    wr_en_n    = (state_n == WRITE);
    err_n      = (state_n == ERR);
    done_n     = settled;
    cpu_hold_n = !settled;
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed and randomized loads compared
// against a word-list model of the expected memory writes and handshake timing.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready_o, wr_en_o, cpu_hold_o, done_o, err_o;
  logic [31:0] wr_addr_o, wr_data_o;
  logic [15:0] word_cnt_o;

  instr_loader #(.ADDR_BASE(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready_o),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .cpu_hold_o (cpu_hold_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .word_cnt_o (word_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [63:0] wr_q[$];
  logic [31:0] words[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (wr_en_o === 1'b1) wr_q.push_back({wr_addr_o, wr_data_o});

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one byte until the loader takes it; acc_cyc records the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, input bit gap);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    while (!got && n < 50) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready_o === 1'b1) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      n++;
    end
    checkOutput("byte_accepted", 32'(got), 32'd1);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams a complete load of len words taken from the words queue.
  task automatic runLoad(input int len, input bit gap, input bit poke_start);
    logic [15:0] len16;
    logic [31:0] w;
    int last_acc;
    int n;
    bit hit;
    len16 = 16'(len);
    last_acc = 0;
    wr_q.delete();
    pulseStart();
    checkOutput("start_ready", 32'(in_ready_o), 32'd1);
    checkOutput("start_hold", 32'(cpu_hold_o), 32'd1);
    checkOutput("start_done", 32'(done_o), 32'd0);
    checkOutput("start_cnt", 32'(word_cnt_o), 32'd0);
    applyStimulus(len16[15:8], gap);
    applyStimulus(len16[7:0], gap);
    if (len == 0 || len > MAXW) begin
      @(negedge clk);
      in_valid = 1'b0;
      hit = 1'b0;
      n = 0;
      while (!hit && n < 8) begin
        if ((len == 0 && done_o === 1'b1) || (len != 0 && err_o === 1'b1)) hit = 1'b1;
        else begin
          @(negedge clk);
          n++;
        end
      end
      checkOutput(len == 0 ? "len0_done" : "err_flag", 32'(hit), 32'd1);
      checkOutput("end_hold", 32'(cpu_hold_o), (len == 0) ? 32'd0 : 32'd1);
      checkOutput("end_ready", 32'(in_ready_o), 32'd0);
      checkOutput("no_writes", 32'(wr_q.size()), 32'd0);
      checkOutput("end_cnt", 32'(word_cnt_o), 32'd0);
    end else begin
      for (int i = 0; i < len; i++) begin
        w = words[i];
        for (int k = 0; k < 4; k++) begin
          applyStimulus(w[31-8*k -: 8], gap);
          if (k == 0 && i > 0 && !gap)
            checkOutput("write_stall", 32'(acc_cyc - last_acc), 32'd2);
          if (k == 0 && i == 0 && poke_start) begin
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checkOutput("poke_cnt", 32'(word_cnt_o), 32'd0);
            checkOutput("poke_ready", 32'(in_ready_o), 32'd1);
            checkOutput("poke_hold", 32'(cpu_hold_o), 32'd1);
          end
          if (k == 3) last_acc = acc_cyc;
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("last_wr_en", 32'(wr_en_o), 32'd1);
      checkOutput("last_wr_ready", 32'(in_ready_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("done_flag", 32'(done_o), 32'd1);
      checkOutput("done_hold", 32'(cpu_hold_o), 32'd0);
      checkOutput("done_cnt", 32'(word_cnt_o), 32'(len));
      checkOutput("write_count", 32'(wr_q.size()), 32'(len));
      for (int i = 0; i < len && i < wr_q.size(); i++) begin
        checkOutput("wr_addr", wr_q[i][63:32], BASE + 32'(4 * i));
        checkOutput("wr_data", wr_q[i][31:0], words[i]);
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(in_ready_o), 32'd0);
    checkOutput({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    checkOutput({tag, "_addr"}, wr_addr_o, BASE);
    checkOutput({tag, "_data"}, wr_data_o, 32'd0);
    checkOutput({tag, "_hold"}, 32'(cpu_hold_o), 32'd1);
    checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_o), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(word_cnt_o), 32'd0);
  endtask

  initial begin
    int len;
    #1 rst = 1'b1;
    #10;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed two-word load");
    words = '{32'h2008_0005, 32'h2009_000A};
    runLoad(2, 1'b0, 1'b0);

    $display("[TB] zero-length load");
    runLoad(0, 1'b0, 1'b0);

    $display("[TB] oversized count then recovery");
    runLoad(5, 1'b0, 1'b0);
    words = '{32'h1122_3344};
    runLoad(1, 1'b0, 1'b0);

    $display("[TB] three-word load with toggling valid");
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    runLoad(3, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-word");
    words = '{32'hA5A5_0F0F};
    pulseStart();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'hDE, 1'b0);
    applyStimulus(8'hAD, 1'b0);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    rst = 1'b0;
    runLoad(1, 1'b0, 1'b0);

    $display("[TB] start pulse ignored during DATA");
    words = '{$urandom, $urandom};
    runLoad(2, 1'b0, 1'b1);

    $display("[TB] randomized loads");
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, MAXW);
      words.delete();
      for (int i = 0; i < len; i++) words.push_back($urandom);
      runLoad(len, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
